// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencing into the IF/ID latch; fetched words appear one cycle after imem_ready.
// When decode stalls, one extra word is parked in a skid register and requests pause until the latch frees.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic [15:0] skid_pc_q, skid_pc_d;
  logic        vld_d;
  logic [15:0] instr_d, ipc_d;
  logic        latch_free;

  assign latch_free = !if_valid || !stall;
  assign imem_addr  = addr_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    vld_d        = if_valid && stall;
    instr_d      = if_instr;
    ipc_d        = if_pc;
    imem_req     = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          pc_d = pc_q + PC_INC;
          if (latch_free) begin
            vld_d   = 1'b1;
            instr_d = imem_rdata;
            ipc_d   = pc_q;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (latch_free) begin
          vld_d   = 1'b1;
          instr_d = skid_instr_q;
          ipc_d   = skid_pc_q;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (imem_ready) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase

    // A request still outstanding must be drained before the target is fetched.
    if (redirect_valid) begin
      pc_d         = redirect_pc;
      vld_d        = 1'b0;
      skid_instr_d = '0;
      skid_pc_d    = '0;
      if ((state_q == FETCH || state_q == DRAIN) && !imem_ready) state_d = DRAIN;
      else                                                    state_d = FETCH;
    end
  end

  // The address register holds the in-flight address while draining, else follows pc.
  assign addr_d = (state_d == DRAIN) ? addr_q : pc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      if_valid     <= vld_d;
      if_instr     <= instr_d;
      if_pc        <= ipc_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: a program-order model predicts each delivered word; a monitor compares at the latch.
module tb_fetch_sequencer;

  localparam logic [15:0] RST_PC = 16'h0010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(RST_PC), .PC_INC(16'h0001)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } word_t;

  int    checks = 0;
  int    passes = 0;
  int    pops   = 0;
  word_t exp_q[$];

  logic [15:0] model_pc     = RST_PC;
  bit          drain_pend   = 1'b0;
  bit          expect_clear = 1'b0;
  bit          prev_wait    = 1'b0;
  logic [15:0] prev_addr    = 16'h0000;

  int lat_cfg  = 0;
  bit mem_busy = 1'b0;
  int mem_cnt  = 0;
  int mem_lat  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder plus the program-order reference model.
  always begin
    @(posedge clk);
    #1;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = 0;
        mem_lat  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      end
      imem_ready = (mem_cnt == mem_lat);
      imem_rdata = imem_addr ^ 16'hA5A5;
    end else begin
      imem_ready = 1'($urandom_range(0, 1));
      imem_rdata = 16'($urandom);
    end
    @(negedge clk);
    #1;
    if (!rst_n) begin
      exp_q.delete();
      model_pc     = RST_PC;
      drain_pend   = 1'b0;
      mem_busy     = 1'b0;
      prev_wait    = 1'b0;
      expect_clear = 1'b0;
    end else begin
      if (prev_wait) begin
        chk("addr_hold_req", {31'b0, imem_req}, 32'd1);
        chk("addr_hold", {16'b0, imem_addr}, {16'b0, prev_addr});
      end
      prev_wait = imem_req && !imem_ready;
      prev_addr = imem_addr;
      if (imem_req) begin
        if (imem_ready) mem_busy = 1'b0;
        else            mem_cnt++;
      end
      if (redirect_valid) begin
        exp_q.delete();
        model_pc     = redirect_pc;
        drain_pend   = imem_req && !imem_ready;
        expect_clear = 1'b1;
      end else if (imem_req && imem_ready) begin
        if (drain_pend) begin
          drain_pend = 1'b0;
        end else begin
          chk("req_addr", {16'b0, imem_addr}, {16'b0, model_pc});
          exp_q.push_back({model_pc ^ 16'hA5A5, model_pc});
          model_pc = model_pc + 16'd1;
        end
      end
    end
  end

  // Monitor: compares the latch against the oldest predicted word, pops on acceptance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (expect_clear) begin
        chk("redirect_clears_valid", {31'b0, if_valid}, 32'd0);
        expect_clear = 1'b0;
      end
      if (if_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL sb_underflow: got live word at pc %h, expected none", if_pc);
        end else begin
          chk("latch_word", {if_instr, if_pc}, exp_q[0]);
          if (!stall) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
    end
  end

  logic [15:0] p0;
  logic [15:0] a0;
  int          n;

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    lat_cfg        = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", {16'b0, imem_addr}, {16'b0, RST_PC});
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", {16'b0, if_instr}, 32'd0);
    chk("rst_pc", {16'b0, if_pc}, 32'd0);

    // Zero-wait memory after reset.
    rst_n = 1'b1;
    step();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", {16'b0, imem_addr}, 32'h0010);
    step();
    chk("zw_valid0", {31'b0, if_valid}, 32'd1);
    chk("zw_pc0", {16'b0, if_pc}, 32'h0010);
    step();
    chk("zw_pc1", {16'b0, if_pc}, 32'h0011);
    step();
    chk("zw_pc2", {16'b0, if_pc}, 32'h0012);

    // Three wait cycles per request: one word every 4 cycles.
    lat_cfg = 3;
    repeat (6) step();
    n = 0;
    while (!if_valid && n < 20) begin step(); n++; end
    chk("lat3_wait_valid", {31'b0, if_valid}, 32'd1);
    step();
    chk("lat3_off1", {31'b0, if_valid}, 32'd0);
    a0 = imem_addr;
    step();
    chk("lat3_off2", {31'b0, if_valid}, 32'd0);
    chk("lat3_addr2", {16'b0, imem_addr}, {16'b0, a0});
    step();
    chk("lat3_off3", {31'b0, if_valid}, 32'd0);
    chk("lat3_addr3", {16'b0, imem_addr}, {16'b0, a0});
    step();
    chk("lat3_off4", {31'b0, if_valid}, 32'd1);

    // Stall for 4 cycles with zero-wait memory: second word parks in the skid.
    lat_cfg = 0;
    repeat (6) step();
    n = 0;
    while (!if_valid && n < 20) begin step(); n++; end
    chk("stall_wait_valid", {31'b0, if_valid}, 32'd1);
    stall = 1'b1;
    p0 = if_pc;
    step();
    chk("stall_hold_req1", {31'b0, imem_req}, 32'd0);
    chk("stall_hold_pc1", {16'b0, if_pc}, {16'b0, p0});
    step();
    step();
    chk("stall_hold_pc3", {16'b0, if_pc}, {16'b0, p0});
    step();
    stall = 1'b0;
    chk("stall_hold_req4", {31'b0, imem_req}, 32'd0);
    step();
    chk("skid_load_pc", {16'b0, if_pc}, {16'b0, p0 + 16'd1});
    chk("skid_load_valid", {31'b0, if_valid}, 32'd1);
    chk("skid_refetch_req", {31'b0, imem_req}, 32'd1);

    // Redirect during a pending request at 0005 with 2 wait cycles.
    repeat (3) step();
    lat_cfg        = 2;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0005;
    step();
    redirect_valid = 1'b0;
    n = 0;
    while (!(imem_req && imem_addr == 16'h0005) && n < 20) begin step(); n++; end
    chk("drain_setup_addr", {16'b0, imem_addr}, 32'h0005);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0200;
    step();
    redirect_valid = 1'b0;
    chk("drain_addr1", {16'b0, imem_addr}, 32'h0005);
    chk("drain_valid1", {31'b0, if_valid}, 32'd0);
    step();
    chk("drain_addr2", {16'b0, imem_addr}, 32'h0005);
    chk("drain_valid2", {31'b0, if_valid}, 32'd0);
    step();
    chk("drain_target_addr", {16'b0, imem_addr}, 32'h0200);
    chk("drain_target_req", {31'b0, imem_req}, 32'd1);
    chk("drain_valid3", {31'b0, if_valid}, 32'd0);

    // Redirect in the same cycle as a returning word under stall.
    lat_cfg = 0;
    repeat (6) step();
    n = 0;
    while (!if_valid && n < 20) begin step(); n++; end
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0300;
    step();
    redirect_valid = 1'b0;
    chk("rdstall_valid", {31'b0, if_valid}, 32'd0);
    chk("rdstall_req", {31'b0, imem_req}, 32'd1);
    chk("rdstall_addr", {16'b0, imem_addr}, 32'h0300);
    step();
    stall = 1'b0;
    repeat (3) step();

    // PC wrap at FFFF.
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFF;
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr0", {16'b0, imem_addr}, 32'hFFFF);
    step();
    chk("wrap_pc0", {16'b0, if_pc}, 32'hFFFF);
    chk("wrap_addr1", {16'b0, imem_addr}, 32'h0000);
    step();
    chk("wrap_pc1", {16'b0, if_pc}, 32'h0000);

    // Random latency, stall and redirect traffic.
    lat_cfg = -1;
    for (int i = 0; i < 3000; i++) begin
      stall          = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'hFFFD + 16'($urandom_range(0, 5))
                                                   : 16'($urandom);
      step();
    end
    stall          = 1'b0;
    redirect_valid = 1'b0;
    repeat (10) step();
    chk("progress", {31'b0, pops >= 200}, 32'd1);

    // Asynchronous reset in the middle of a pending request.
    lat_cfg = 3;
    n = 0;
    while (!(imem_req && !imem_ready) && n < 20) begin step(); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_addr", {16'b0, imem_addr}, {16'b0, RST_PC});
    chk("arst_valid", {31'b0, if_valid}, 32'd0);
    chk("arst_instr", {16'b0, if_instr}, 32'd0);
    chk("arst_pc", {16'b0, if_pc}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
